// File: rtl/button_conditioner.sv
// Five-button conditioner: 2-flop sync, debounce, press/release pulses and a one-deep command slot.
// Auto-repeat of held buttons is built only when the BTN_REPEAT_EN macro is defined.
module button_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         REPEAT_DELAY    = 25000000,
  parameter int         REPEAT_PERIOD   = 5000000,
  parameter logic [4:0] REPEAT_MASK     = 5'b11111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_n,
  output logic [4:0] btn_level_n,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready
);

  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       r_sync_p0;
  logic [4:0]       r_sync_p1;
  logic [4:0]       r_level;
  logic [4:0]       r_press;
  logic [4:0]       r_release;
  logic [CNT_W-1:0] r_cnt [5];
  logic [4:0]       w_flip;
  logic [4:0]       w_rep_hit;

  logic [4:0]       r_pending;
  logic             r_cmd_valid;
  logic [2:0]       r_cmd_code;
  logic [4:0]       w_grant;
  logic [2:0]       w_grant_idx;
  logic             w_slot_load;

  // A level is accepted on the edge where the count completes and the input still differs
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 5; i++) begin
      w_flip[i] = (r_sync_p1[i] != r_level[i]) && (r_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
      r_level   <= '1;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_sync_p0 <= btn_n;
      r_sync_p1 <= r_sync_p0;
      for (int i = 0; i < 5; i++) begin
        if (r_sync_p1[i] == r_level[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
        r_press[i]   <= (w_flip[i] & r_level[i]) | w_rep_hit[i];
        r_release[i] <= w_flip[i] & ~r_level[i];
      end
      r_level <= r_level ^ w_flip;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int               REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               REP_W     = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] r_rep_cnt [5];
  logic [4:0]       r_rep_first;

  // A release accepted on the same edge suppresses a coincident repeat
  always_comb begin
    w_rep_hit = '0;
    for (int i = 0; i < 5; i++) begin
      if (REPEAT_MASK[i] && !r_level[i] && !w_flip[i]) begin
        w_rep_hit[i] = r_rep_first[i] ? (r_rep_cnt[i] == REP_FIRST) : (r_rep_cnt[i] == REP_NEXT);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (!rst_n || r_level[i] || !REPEAT_MASK[i]) begin
        r_rep_cnt[i]   <= '0;
        r_rep_first[i] <= 1'b1;
      end else if (w_rep_hit[i]) begin
        r_rep_cnt[i]   <= '0;
        r_rep_first[i] <= 1'b0;
      end else begin
        r_rep_cnt[i]   <= r_rep_cnt[i] + 1'b1;
      end
    end
  end
`else
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY, REPEAT_PERIOD};
  assign w_rep_hit           = '0;
`endif

  // Lowest-index pending button wins the slot
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    for (int i = 4; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_grant     = '0;
        w_grant[i]  = 1'b1;
        w_grant_idx = 3'(i);
      end
    end
  end

  assign w_slot_load = !r_cmd_valid || cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= '0;
    end else begin
      if (w_slot_load) begin
        r_cmd_valid <= |r_pending;
        if (|r_pending) r_cmd_code <= w_grant_idx;
      end
      // A press landing on a bit being granted keeps that bit set
      r_pending <= (r_pending & ~(w_slot_load ? w_grant : 5'b0)) | r_press;
    end
  end

  assign btn_level_n = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_code    = r_cmd_code;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4: directed scenarios plus random buttons,
// all cycles compared against a sample-window behavioural model.
module tb_button_conditioner;
  localparam int         D     = 4;
  localparam int         RD    = 10;
  localparam int         RP    = 5;
  localparam logic [4:0] RMASK = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_n;
  logic       cmd_ready;
  logic [4:0] btn_level_n, btn_press, btn_release;
  logic       cmd_valid;
  logic [2:0] cmd_code;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (RMASK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .btn_level_n(btn_level_n),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: synced sample = raw input two edges back; level accepts a new value once the
  // last D synced samples all disagree with it.
  logic [4:0] m_pipe[$];
  logic [4:0] m_win[$];
  logic [4:0] m_level, m_press, m_rel, m_pend;
  logic       m_valid;
  logic [2:0] m_code;
  bit         m_live = 0;
  int         m_edge = 0;
  int         m_t0[5];

  always @(posedge clk) begin : model
    logic [4:0] s, flip, nxt_p, nxt_r, grant;
    bit         all_diff;
    m_edge++;
    if (!rst_n) begin
      m_pipe = {5'h1f, 5'h1f};
      m_win.delete();
      for (int k = 0; k < D; k++) m_win.push_back(5'h1f);
      m_level = 5'h1f; m_press = '0; m_rel = '0; m_pend = '0;
      m_valid = 1'b0;  m_code = '0;  m_live = 1;
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(btn_n);
      m_win.push_back(s);
      void'(m_win.pop_front());
      flip = '0;
      for (int i = 0; i < 5; i++) begin
        all_diff = 1;
        for (int k = 0; k < m_win.size(); k++) if (m_win[k][i] == m_level[i]) all_diff = 0;
        flip[i] = all_diff;
      end
      nxt_p = flip & m_level;
      nxt_r = flip & ~m_level;
`ifdef BTN_REPEAT_EN
      for (int i = 0; i < 5; i++) begin
        int age;
        age = m_edge - m_t0[i];
        if (RMASK[i] && !m_level[i] && !flip[i] && (age == RD || (age > RD && (age - RD) % RP == 0)))
          nxt_p[i] = 1'b1;
        if (flip[i] && m_level[i]) m_t0[i] = m_edge;
      end
`endif
      grant = '0;
      if (!m_valid || cmd_ready) begin
        m_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
          if (m_pend[i] && !m_valid) begin
            m_valid  = 1'b1;
            m_code   = 3'(i);
            grant[i] = 1'b1;
          end
        end
      end
      m_pend  = (m_pend & ~grant) | m_press;
      m_level = m_level ^ flip;
      m_press = nxt_p;
      m_rel   = nxt_r;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (m_live) begin
      chk("model_level", int'(btn_level_n), int'(m_level));
      chk("model_press", int'(btn_press), int'(m_press));
      chk("model_release", int'(btn_release), int'(m_rel));
      chk("model_valid", int'(cmd_valid), int'(m_valid));
      if (m_valid) chk("model_code", int'(cmd_code), int'(m_code));
    end
  endtask

  task automatic wait_pulse(input int which, input bit rel, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40 && cyc < 0; k++) begin
      tick();
      if (rel ? btn_release[which] : btn_press[which]) cyc = k;
    end
  endtask

  task automatic ready_pulse();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [4:0] acc;
    logic acc_v;
    rst_n = 1'b0; btn_n = 5'h1f; cmd_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_level", int'(btn_level_n), 31);
    chk("reset_press", int'(btn_press), 0);
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_code", int'(cmd_code), 0);

    // Idle lines stay quiet
    acc = '0; acc_v = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      acc = acc | btn_press | btn_release;
      acc_v = acc_v | cmd_valid;
    end
    chk("idle_events", int'(acc), 0);
    chk("idle_valid", int'(acc_v), 0);
    chk("idle_level", int'(btn_level_n), 31);

    // Glitch of 3 cycles is discarded, then a held fall is accepted
    btn_n[2] = 1'b0; acc = '0;
    for (int k = 0; k < 3; k++) begin tick(); acc = acc | btn_press | btn_release; end
    btn_n[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin tick(); acc = acc | btn_press | btn_release; end
    btn_n[2] = 1'b0;
    chk("glitch_quiet", int'(acc), 0);
    wait_pulse(2, 1'b0, cyc);
    chk("press2_latency", cyc, 6);
    chk("press2_level", int'(btn_level_n), 27);
    tick();
    chk("press2_single", int'(btn_press), 0);
    chk("cmd2_not_yet", int'(cmd_valid), 0);
    tick();
    chk("cmd2_valid", int'(cmd_valid), 1);
    chk("cmd2_code", int'(cmd_code), 2);
    ready_pulse();
    chk("cmd2_consumed", int'(cmd_valid), 0);

    // Simultaneous presses drain in ascending order
    btn_n[1] = 1'b0; btn_n[4] = 1'b0;
    wait_pulse(1, 1'b0, cyc);
    chk("press14_latency", cyc, 6);
    chk("press14_bits", int'(btn_press), 18);
    tick(); tick();
    chk("cmd1_valid", int'(cmd_valid), 1);
    chk("cmd1_code", int'(cmd_code), 1);
    repeat (3) tick();
    chk("cmd1_held", int'(cmd_code), 1);
    ready_pulse();
    chk("cmd4_valid", int'(cmd_valid), 1);
    chk("cmd4_code", int'(cmd_code), 4);
    repeat (2) tick();
    chk("cmd4_held", int'(cmd_code), 4);
    ready_pulse();
    chk("cmd_drained", int'(cmd_valid), 0);

    // Release produces a pulse but no command
    btn_n[2] = 1'b1;
    wait_pulse(2, 1'b1, cyc);
    chk("release2_latency", cyc, 6);
    chk("release2_level", int'(btn_level_n[2]), 1);
    acc_v = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); acc_v = acc_v | cmd_valid; end
    chk("release_no_cmd", int'(acc_v), 0);
    btn_n = 5'h1f;
    repeat (10) tick();

    // Reset mid-debounce; held button is accepted after reset release
    btn_n[3] = 1'b0;
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_mid_level", int'(btn_level_n), 31);
    chk("rst_mid_valid", int'(cmd_valid), 0);
    wait_pulse(3, 1'b0, cyc);
    chk("press3_after_reset", cyc, 6);
    tick(); tick();
    chk("cmd3_code", int'(cmd_code), 3);
    ready_pulse();
    btn_n = 5'h1f;
    repeat (10) tick();

`ifdef BTN_REPEAT_EN
    begin
      int times[$];
      int exp_t[8] = '{0, 10, 15, 20, 25, 30, 35, 40};
      cmd_ready = 1'b1;
      btn_n[0] = 1'b0;
      wait_pulse(0, 1'b0, cyc);
      chk("press0_latency", cyc, 6);
      times.push_back(0);
      for (int k = 1; k <= 60; k++) begin
        tick();
        if (btn_press[0]) times.push_back(k);
        if (k == 38) btn_n[0] = 1'b1;
      end
      chk("repeat_count", times.size(), 8);
      for (int i = 0; i < 8 && i < times.size(); i++) chk("repeat_time", times[i], exp_t[i]);
      cmd_ready = 1'b0;
    end
`endif

    // Random buttons, handshakes and occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) btn_n[i] = ~btn_n[i];
      cmd_ready = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
